// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        GO      = 3'd2,
        DONE    = 3'd3,
        FOUL    = 3'd4,
        TIMEOUT = 3'd5
    } gameStateT;

    localparam logic [15:0] BCD_MAX = 16'h9999;
    localparam int unsigned DELAY_W = 13;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the reaction-time counter; carries out on 9 -> 0.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/reaction_game_fsm.sv
// Reaction-game sequencer: random wait, ms BCD reaction timer, best time and foul detection.
// The LFSR input is named randVal because rand is a reserved word in SystemVerilog.
module reaction_game_fsm
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        react,
    input  logic        clear_best,
    input  logic [15:0] randVal,
    output logic        go_led,
    output logic        foul,
    output logic [15:0] time_bcd,
    output logic [15:0] best_bcd,
    output logic        new_best,
    output logic [2:0]  state
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DELAY_W-1:0] MIN_LOAD = DELAY_W'(MIN_DELAY_MS);

    gameStateT          curState, nextState;
    logic [PRE_W-1:0]   presc;
    logic [DELAY_W-1:0] delayCnt;
    logic [DELAY_W-1:0] delayLoad;
    logic               running;
    logic               tick;
    logic               saturated;
    logic               countEn;
    logic [3:0]         carry;
    logic               unusedRandHi;

    assign unusedRandHi = ^randVal[15:12];
    assign delayLoad    = MIN_LOAD + {1'b0, randVal[11:0]};
    assign running      = (curState == ARMED) || (curState == GO);
    assign tick         = running && (presc == PRE_LAST);
    assign saturated    = (time_bcd == BCD_MAX);
    // react and start both take precedence over a coincident tick
    assign countEn      = (curState == GO) && tick && !react && !start && !saturated;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        if (start) begin
            nextState = ARMED;
        end else begin
            case (curState)
                ARMED: begin
                    if (react) begin
                        nextState = FOUL;
                    end else if (tick && (delayCnt <= DELAY_W'(1))) begin
                        nextState = GO;
                    end
                end
                GO: begin
                    if (react) begin
                        nextState = DONE;
                    end else if (tick && saturated) begin
                        nextState = TIMEOUT;
                    end
                end
                default: nextState = curState;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (start || !running) begin
            presc <= '0;
        end else begin
            presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delayCnt <= '0;
        end else if (start) begin
            delayCnt <= delayLoad;
        end else if ((curState == ARMED) && tick && !react && (delayCnt != '0)) begin
            delayCnt <= delayCnt - DELAY_W'(1);
        end
    end

    // Best time is captured on the react edge so it and new_best appear on DONE entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_bcd <= BCD_MAX;
            new_best <= 1'b0;
        end else begin
            new_best <= 1'b0;
            if (clear_best) begin
                best_bcd <= BCD_MAX;
            end else if (!start && (curState == GO) && react && (time_bcd < best_bcd)) begin
                best_bcd <= time_bcd;
                new_best <= 1'b1;
            end
        end
    end

    bcd_digit u_digit0 (.clk(clk), .reset(reset), .clr(start), .inc(countEn),
                        .digit(time_bcd[3:0]),   .carry(carry[0]));
    bcd_digit u_digit1 (.clk(clk), .reset(reset), .clr(start), .inc(carry[0]),
                        .digit(time_bcd[7:4]),   .carry(carry[1]));
    bcd_digit u_digit2 (.clk(clk), .reset(reset), .clr(start), .inc(carry[1]),
                        .digit(time_bcd[11:8]),  .carry(carry[2]));
    bcd_digit u_digit3 (.clk(clk), .reset(reset), .clr(start), .inc(carry[2]),
                        .digit(time_bcd[15:12]), .carry(carry[3]));

    assign go_led = (curState == GO);
    assign foul   = (curState == FOUL);
    assign state  = curState;

endmodule
